// File: rtl/ssp_pkg.sv
// Shared constants and types for the SSP transmit path.
package ssp_pkg;
  localparam int WORD_W     = 8;
  localparam int FRAME_PCLK = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Talker read/write strobe: READ (0) means the talker takes txdata this cycle.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/ssp_rr_picker.sv
// Combinational round-robin picker: first eligible channel after 'last', wrapping.
module ssp_rr_picker #(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input  logic [NCH-1:0] e,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] sel,
  output logic           any
);
  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v % NCH);
  endfunction

  // Walk from the farthest offset down so the nearest eligible channel wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = NCH; k >= 1; k--) begin
      if (e[wrap(int'(last) + k)]) begin
        sel = wrap(int'(last) + k);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ssp_tx_arbiter.sv
// Round-robin arbiter sharing one SSP talker among NCH word requesters.
module ssp_tx_arbiter
  import ssp_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int IDW        = 2,
  parameter int FRAME_PCLK = ssp_pkg::FRAME_PCLK
) (
  input  logic                         pclk,
  input  logic                         clear,
  input  logic [NCH-1:0]               ch_en,
  input  logic [NCH-1:0]               req_valid,
  input  logic [NCH-1:0][WORD_W-1:0]   req_data,
  output logic [NCH-1:0]               req_pop,
  output logic [WORD_W-1:0]            txdata,
  output logic                         txhasword,
  input  logic                         txfifo_rw,
  input  logic                         rxfifoint,
  output logic [IDW-1:0]               grant_id,
  output logic                         busy
);
  localparam int CW = $clog2(FRAME_PCLK) + 1;

  state_t            state, state_n;
  logic [CW-1:0]     counter, counter_n;
  logic [IDW-1:0]    last, last_n;
  logic [IDW-1:0]    grant_n, sel;
  logic [WORD_W-1:0] txdata_n;
  logic [NCH-1:0]    pop_n;
  logic              hw_n, busy_n, any;

  ssp_rr_picker #(.NCH(NCH), .IDW(IDW)) u_pick (
    .e    (req_valid & ch_en),
    .last (last),
    .sel  (sel),
    .any  (any)
  );

  always_comb begin
    state_n   = state;
    counter_n = counter;
    last_n    = last;
    grant_n   = grant_id;
    txdata_n  = txdata;
    pop_n     = '0;
    hw_n      = txhasword;
    busy_n    = busy;
    case (state)
      IDLE: begin
        if (!rxfifoint && any) begin
          txdata_n   = req_data[sel];
          grant_n    = sel;
          last_n     = sel;
          pop_n[sel] = 1'b1;
          hw_n       = 1'b1;
          busy_n     = 1'b1;
          state_n    = OFFER;
        end
      end
      OFFER: begin
        if (txfifo_rw == RW_READ) begin
          hw_n      = 1'b0;
          counter_n = CW'(FRAME_PCLK - 1);
          state_n   = HOLD;
        end
      end
      HOLD: begin
        if (counter == '0) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          counter_n = counter - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      counter   <= '0;
      last      <= IDW'(NCH - 1);
      grant_id  <= '0;
      txdata    <= '0;
      req_pop   <= '0;
      txhasword <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      counter   <= counter_n;
      last      <= last_n;
      grant_id  <= grant_n;
      txdata    <= txdata_n;
      req_pop   <= pop_n;
      txhasword <= hw_n;
      busy      <= busy_n;
    end
  end
endmodule

// File: tb/tb_ssp_tx_arbiter.sv
// Directed bench for ssp_tx_arbiter with a grant scoreboard checked on every pop.
module tb_ssp_tx_arbiter;
  logic             pclk = 1'b0;
  logic             clear;
  logic [3:0]       ch_en, req_valid, req_pop;
  logic [3:0][7:0]  req_data;
  logic [7:0]       txdata;
  logic             txhasword, txfifo_rw, rxfifoint, busy;
  logic [1:0]       grant_id;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, n_pops = 0, last_pop = 0, gap = 0;

  ssp_tx_arbiter #(.NCH(4), .IDW(2), .FRAME_PCLK(18)) dut (
    .pclk(pclk), .clear(clear), .ch_en(ch_en), .req_valid(req_valid),
    .req_data(req_data), .req_pop(req_pop), .txdata(txdata),
    .txhasword(txhasword), .txfifo_rw(txfifo_rw), .rxfifoint(rxfifoint),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch; e.data = d;
    sb.push_back(e);
  endtask

  // One clock: sample 1ns after the edge, score any pop against the queue.
  task automatic tick();
    exp_t e;
    @(posedge pclk);
    #1;
    cyc++;
    if (clear && req_pop != 4'b0) begin
      n_pops++;
      gap      = cyc - last_pop;
      last_pop = cyc;
      chk("pop_onehot", 32'($onehot(req_pop)), 1);
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pop_grant_id", 32'(grant_id), 32'(e.ch));
        chk("pop_txdata", 32'(txdata), 32'(e.data));
        chk("pop_strobe", 32'(req_pop), 32'(1 << e.ch));
        chk("pop_txhasword", 32'(txhasword), 1);
      end
    end
  endtask

  task automatic wait_pop(input string tag);
    int tgt = n_pops + 1;
    int k = 0;
    while (n_pops < tgt && k < 60) begin tick(); k++; end
    chk(tag, 32'(n_pops), 32'(tgt));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin tick(); k++; end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_outs"}, {req_pop, txdata, txhasword, busy, grant_id}, 0);
  endtask

  initial begin
    int n, hwc, bad, base;
    clear = 1'b0; ch_en = '0; req_valid = '0; req_data = '0;
    txfifo_rw = 1'b1; rxfifoint = 1'b0;
    repeat (3) tick();
    chk_reset("reset");
    clear = 1'b1;
    tick();

    // Single channel: talker accepts after 4 offer cycles.
    ch_en = 4'b1111;
    req_data[0] = 8'hA5;
    push(0, 8'hA5);
    req_valid = 4'b0001;
    wait_pop("single_pop");
    n = 0; hwc = 0;
    while (busy && n < 300) begin
      n++;
      if (txhasword) hwc++;
      if (n == 2) begin req_data[0] = 8'hB6; push(0, 8'hB6); end
      txfifo_rw = (n == 4) ? 1'b0 : 1'b1;
      tick();
    end
    chk("single_offer_cycles", 32'(hwc), 4);
    chk("single_busy_cycles", 32'(n), 22);
    tick();
    chk("single_second_pop", 32'(n_pops), 2);
    chk("single_second_gap", 32'(gap), 23);
    req_valid = '0;
    txfifo_rw = 1'b0;
    wait_idle("single_idle");

    // Round robin from reset: 0,1,2,3,0 with FRAME_PCLK+2 spacing.
    clear = 1'b0;
    #1;
    chk_reset("reset_idle");
    clear = 1'b1;
    tick();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
    req_valid = 4'b1111;
    for (int p = 1; p <= 5; p++) begin
      wait_pop("rr_pop");
      if (p > 1) chk("rr_gap", 32'(gap), 20);
    end
    req_valid = '0;
    wait_idle("rr_idle");

    // Skipping with E=1010: 1, then 3 (ch_en[3] dropped in OFFER), then 1.
    push(1, 8'h11); push(3, 8'h13); push(1, 8'h11);
    req_valid = 4'b1010;
    wait_pop("skip_pop1");
    wait_pop("skip_pop3");
    txfifo_rw = 1'b1;
    ch_en = 4'b0111;
    repeat (3) tick();
    chk("skip_offer_kept", {30'd0, txhasword, busy}, 3);
    chk("skip_offer_gid", 32'(grant_id), 3);
    txfifo_rw = 1'b0;
    wait_pop("skip_pop1b");
    req_valid = '0;
    wait_idle("skip_idle");

    // Backpressure: rxfifoint blocks grants.
    ch_en = 4'b1111;
    txfifo_rw = 1'b1;
    rxfifoint = 1'b1;
    req_data[2] = 8'hC3;
    req_valid = 4'b0100;
    base = n_pops;
    bad = 0;
    repeat (50) begin
      tick();
      if (req_pop != 4'b0 || txhasword) bad++;
    end
    chk("bp_blocked_cycles", 32'(bad), 0);
    push(2, 8'hC3);
    rxfifoint = 1'b0;
    tick();
    chk("bp_grant_next", 32'(n_pops), 32'(base + 1));

    // Stall in OFFER, rxfifoint rising midway must not withdraw the word.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) rxfifoint = 1'b1;
      tick();
      if (!txhasword || txdata != 8'hC3 || n_pops != base + 1 || grant_id != 2'd2) bad++;
    end
    chk("stall_stable_cycles", 32'(bad), 0);
    req_valid = '0;
    rxfifoint = 1'b0;
    txfifo_rw = 1'b0;
    repeat (6) tick();
    chk("hold_state", {29'd0, busy, txhasword, grant_id == 2'd2}, 32'b101);

    // Reset mid-HOLD, then channel 0 granted one cycle after release.
    clear = 1'b0;
    #1;
    chk_reset("reset_hold");
    tick();
    tick();
    req_data[0] = 8'h5A;
    req_valid = 4'b0001;
    push(0, 8'h5A);
    base = n_pops;
    clear = 1'b1;
    tick();
    chk("post_reset_grant", 32'(n_pops), 32'(base + 1));
    req_valid = '0;
    wait_idle("final_idle");
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssp_tx_arbiter.md
Name: ssp_tx_arbiter

Overview:
- Shares the single SSP transmitter (talker) between NCH word requesters.
- Picks one requester per frame by round-robin, pops one 8-bit word from it and presents that word on the talker's txdata/txhasword interface.
- Holds off the next grant until the current serial frame has completed.
- Sits between the per-channel TX FIFOs and the talker, in the pclk domain.

Parameters:
NCH, 4, number of requesting channels (2..8)
IDW, 2, width of grant id, equals clog2(NCH)
FRAME_PCLK, 18, pclk cycles the talker needs per word (fss period plus 8 bits at sspclk = pclk/2)

Ports:
pclk  in  1  SSP clock; all state updates on its rising edge
clear  in  1  asynchronous, active-low reset
ch_en  in  NCH  per-channel enable; a disabled channel is never granted
req_valid  in  NCH  channel i has a word available
req_data  in  8*NCH  word of channel i at bits [8i+7:8i]
req_pop  out  NCH  one-cycle pop strobe to channel i's FIFO
txdata  out  8  word offered to the talker
txhasword  out  1  txdata is valid (talker txhasword)
txfifo_rw  in  1  talker read request; 0 means the talker takes txdata this cycle
rxfifoint  in  1  RX FIFO full; blocks new grants
grant_id  out  IDW  channel of the word currently offered or in flight
busy  out  1  high in OFFER and HOLD

Behaviour:
- Reset (clear=0, async): state=IDLE, txdata=0, txhasword=0, req_pop=0, grant_id=0, busy=0, counter=0, last=NCH-1 so channel 0 wins first.
- Reset mid-frame: a word already popped is discarded. No replay.
- Eligible set: E = req_valid & ch_en.
- IDLE:
  - If rxfifoint=0 and E≠0, pick the first set bit of E searching from last+1 upward, wrapping modulo NCH.
  - Same edge: txdata<=req_data[sel], grant_id<=sel, last<=sel, req_pop[sel]<=1 for exactly one cycle, txhasword<=1, busy<=1, go OFFER.
  - If rxfifoint=1 or E=0, stay in IDLE with all outputs held.
  - Latency from req_valid to txhasword is 1 pclk.
- OFFER:
  - txhasword=1 and txdata stable.
  - When txfifo_rw=0 is sampled: txhasword<=0, counter<=FRAME_PCLK-1, go HOLD.
  - rxfifoint rising while in OFFER does not withdraw the word; the arbiter waits.
  - Changes to ch_en or req_valid in OFFER have no effect on this word.
- HOLD:
  - busy=1, txhasword=0, grant_id held.
  - Counter decrements each pclk. When counter=0: busy<=0, go IDLE.
  - Minimum spacing between consecutive req_pop strobes is FRAME_PCLK+2 pclk (pop, accept, FRAME_PCLK hold cycles).
- Round-robin: last updates only on a grant. A single eligible channel may be granted back-to-back.
- Simultaneous: rxfifoint=1 in the same cycle as a new request means no grant that cycle. All-disabled means permanently IDLE.
- Counter width is clog2(FRAME_PCLK)+1 bits, with no wrap. A counter reaching 0 is the only exit from HOLD.
- req_pop is never asserted outside the IDLE→OFFER transition.
- At most one req_pop bit is high in any cycle.

Decomposition:
- Shared package ssp_pkg holds:
  - WORD_W=8
  - FRAME_PCLK=18
  - state encoding IDLE/OFFER/HOLD (2 bits)
  - the talker rw encoding constants RW_READ=0, RW_WRITE=1
- One sub-module: ssp_rr_picker. It is combinational, with inputs E[NCH] and last[IDW], and outputs sel[IDW] and any. The arbiter instantiates it once.

Test Plan:
- Reset behaviour: clear=0 asserted mid-HOLD with grant_id=2 -> all outputs 0 immediately. After release with E=4'b0001, channel 0 is granted 1 cycle later.
- Single channel: ch0 req_data=8'hA5, talker accepts 3 cycles after txhasword -> txdata=A5, one req_pop[0] pulse. busy lasts 1+3+18 cycles. A second ch0 word is popped 1 cycle after busy falls.
- Round-robin: E=4'b1111 held, talker always accepts -> grant_id sequence 0,1,2,3,0. Each grant is separated by FRAME_PCLK+2 cycles.
- Skipping: E=4'b1010 with last=1 -> next grant 3, then 1. Drop ch_en[3] while ch3's word is in OFFER -> that word still completes, and the next grant is 1.
- Backpressure: rxfifoint=1 with E=4'b0100 -> no req_pop and txhasword=0 for 50 cycles. rxfifoint falls -> grant_id=2 next cycle.
- Stall in OFFER: txfifo_rw held 1 for 100 cycles -> txhasword and txdata stable throughout, with no extra pops.
